// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Op codes follow the EXE-stage encoding; 0 and 7 are never issued legally.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_ILL   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic op_legal(input op_e op);
    return (op != OP_NONE) && (op != OP_ILL);
  endfunction

  function automatic logic op_is_mul(input op_e op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_hilo.sv
// Architectural HI/LO with a staging pair; staged values move into HI/LO
// only on a commit that is not flushed in the same cycle.
module muldiv_hilo
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            stage_en,
  input  logic [XLEN-1:0] stage_hi_d,
  input  logic [XLEN-1:0] stage_lo_d,
  input  logic            commit_req,
  input  logic            cancel,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] stage_hi_q;
  logic [XLEN-1:0] stage_lo_q;
  logic            commit;

  assign commit = commit_req & ~cancel;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stage_hi_q <= '0;
      stage_lo_q <= '0;
    end else if (stage_en) begin
      stage_hi_q <= stage_hi_d;
      stage_lo_q <= stage_lo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= stage_hi_q;
      lo <= stage_lo_q;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: accepts one HI/LO-class op at a time, drives the
// shared engines with a level-held begin, and commits results to HI/LO.
// state | meaning
// IDLE  | ready for a request, both begins low
// MUL   | multiply engine running, waiting for mult_end
// DIV   | divide engine running, waiting for div_end
// DONE  | result staged, done pulse, commit at end of cycle unless cancelled
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  input  logic [2:0]          req_op,
  input  logic [XLEN-1:0]     req_op1,
  input  logic [XLEN-1:0]     req_op2,
  output logic                req_ready,
  input  logic                cancel,
  output logic                mult_begin,
  output logic                mult_sign,
  output logic [XLEN-1:0]     mult_op1,
  output logic [XLEN-1:0]     mult_op2,
  input  logic [2*XLEN-1:0]   product,
  input  logic                mult_end,
  output logic                div_begin,
  output logic                div_sign,
  output logic [XLEN-1:0]     div_op1,
  output logic [XLEN-1:0]     div_op2,
  input  logic [XLEN-1:0]     quotient,
  input  logic [XLEN-1:0]     remainder,
  input  logic                div_end,
  output logic                busy,
  output logic                done,
  output logic [XLEN-1:0]     hi,
  output logic [XLEN-1:0]     lo
);

  state_e          state_q;
  state_e          state_d;
  op_e             op_q;
  op_e             req_op_e;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;
  logic            accept;
  logic            div_zero;

  logic            stage_en;
  logic [XLEN-1:0] stage_hi_d;
  logic [XLEN-1:0] stage_lo_d;

  assign req_op_e = op_e'(req_op);
  assign div_zero = (req_op2 == '0);
  assign accept   = req_valid & req_ready & ~cancel & op_legal(req_op_e);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_is_mul(req_op_e)) begin
            state_d = ST_MUL;
          end else if (op_is_div(req_op_e) && !div_zero) begin
            state_d = ST_DIV;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (mult_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DIV: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (div_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs gated with resetn so they read quiet during the reset cycle itself.
  always_comb begin
    req_ready  = resetn & (state_q == ST_IDLE);
    busy       = resetn & (state_q != ST_IDLE);
    done       = resetn & (state_q == ST_DONE);
    mult_begin = resetn & (state_q == ST_MUL);
    div_begin  = resetn & (state_q == ST_DIV);
    mult_sign  = mult_begin & (op_q == OP_MULT);
    div_sign   = div_begin & (op_q == OP_DIV);
  end

  // Operands are captured once at accept and held for the engine residency.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q  <= OP_NONE;
      op1_q <= '0;
      op2_q <= '0;
    end else if (accept) begin
      op_q  <= req_op_e;
      op1_q <= req_op1;
      op2_q <= req_op2;
    end
  end

  assign mult_op1 = op1_q;
  assign mult_op2 = op2_q;
  assign div_op1  = op1_q;
  assign div_op2  = op2_q;

  // Staged values default to current HI/LO so partial writes keep the other half.
  always_comb begin
    stage_en   = 1'b0;
    stage_hi_d = hi;
    stage_lo_d = lo;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (req_op_e)
            OP_DIV, OP_DIVU: stage_en = div_zero;
            OP_MTHI: begin
              stage_en   = 1'b1;
              stage_hi_d = req_op1;
            end
            OP_MTLO: begin
              stage_en   = 1'b1;
              stage_lo_d = req_op1;
            end
            default: stage_en = 1'b0;
          endcase
        end
      end
      ST_MUL: begin
        if (mult_end && !cancel) begin
          stage_en   = 1'b1;
          stage_hi_d = product[2*XLEN-1:XLEN];
          stage_lo_d = product[XLEN-1:0];
        end
      end
      ST_DIV: begin
        if (div_end && !cancel) begin
          stage_en   = 1'b1;
          stage_hi_d = remainder;
          stage_lo_d = quotient;
        end
      end
      default: stage_en = 1'b0;
    endcase
  end

  muldiv_hilo u_hilo (
    .clk        (clk),
    .resetn     (resetn),
    .stage_en   (stage_en),
    .stage_hi_d (stage_hi_d),
    .stage_lo_d (stage_lo_d),
    .commit_req (state_q == ST_DONE),
    .cancel     (cancel),
    .hi         (hi),
    .lo         (lo)
  );

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multiply/divide sequencer for the execute stage. Accepts one HI/LO-class operation at a time from EXE, drives the shared multi-cycle `multiply` and `divide` engines with the level-held begin handshake, and stages results. It owns the architectural HI/LO registers, commits results only when the operation is not cancelled, and reports busy/done so EXE can hold `EXE_over` low.

## Interface
Parameters:
- none (width fixed at 32)

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: reset, synchronous, active-low.
- `req_valid` in 1: EXE holds a valid mul/div/mthi/mtlo op.
- `req_op` in 3: op code from `muldiv_pkg`: MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 0 and 7 are illegal.
- `req_op1` in 32: rs value.
- `req_op2` in 32: rt value.
- `req_ready` out 1: request accepted this cycle.
- `cancel` in 1: exception/eret flush from WB.
- `mult_begin` out 1, `mult_sign` out 1: held high until `mult_end`.
- `mult_op1`, `mult_op2` out 32: registered operands.
- `product` in 64, `mult_end` in 1.
- `div_begin` out 1, `div_sign` out 1.
- `div_op1`, `div_op2` out 32: registered operands.
- `quotient`, `remainder` in 32, `div_end` in 1.
- `busy` out 1: state != IDLE.
- `done` out 1: high for exactly one cycle per completed op.
- `hi`, `lo` out 32: architectural HI/LO.

## Operation
- States: IDLE, MUL, DIV, DONE (2-bit).
- `req_ready` = resetn & (state==IDLE). Accept = `req_valid` & `req_ready` & !`cancel`.
- On accept, register op, op1 and op2. Next state:
  - MULT/MULTU go to MUL.
  - DIV/DIVU with op2≠0 go to DIV.
  - DIV/DIVU with op2==0 go to DONE; staged hi/lo = current HI/LO, so HI/LO are unchanged.
  - MTHI goes to DONE; staged hi = op1, staged lo = LO.
  - MTLO goes to DONE; staged lo = op1, staged hi = HI.
  - Illegal op: ignored, stay IDLE, `req_ready` stays 1.
- MUL: `mult_begin`=1, `mult_sign`=(op==MULT). On `mult_end`: stage hi=product[63:32], lo=product[31:0], go to DONE.
- DIV: `div_begin`=1, `div_sign`=(op==DIV). On `div_end`: stage hi=remainder, lo=quotient, go to DONE.
- DONE: `done`=1. Go to IDLE. HI/LO take the staged values at that edge unless `cancel`.
- `cancel` in MUL/DIV: go to IDLE next edge, begin drops, nothing staged. This holds even when `*_end` arrives in the same cycle; cancel wins.
- `cancel` in DONE: `done` still reads 1 that cycle, but the commit is suppressed. EXE qualifies `done` with its own flush.
- `cancel` in IDLE: blocks accept.
- Begin signals are low in every IDLE cycle. Engines therefore always see a falling begin between ops.
- `*_op1/2` are driven from registers and stay stable for the whole MUL/DIV residency.

## Timing
- Reset (resetn=0 at edge): state=IDLE, HI=LO=0, staged regs=0, operand regs=0. During reset `busy`=0, `done`=0, both begins 0, both signs 0, `req_ready`=0.
- MTHI/MTLO/div-by-zero: accept at edge E0, DONE in cycle after E0, HI/LO updated at E1. 2 cycles from request to visible value; next accept is possible at E2.
- MULT: accept at E0, begin high from cycle after E0. With `mult_end` seen in cycle k, DONE is cycle k+1 and commit happens at the end of k+1.
- DIV: same as MULT, keyed on `div_end`.
- Throughput: at most one op per (engine latency + 2) cycles.
- `*_end` outside MUL/DIV is ignored.

## Structure
- `muldiv_pkg`: op-code constants, state encoding, width constant 32.
- Sub-module `muldiv_hilo`: HI/LO plus staged registers, with commit and cancel-suppress logic. The controller FSM stays in `muldiv_ctrl`.
- The `multiply` and `divide` engines are instantiated by the parent, not inside this block.

## Test plan
- Reset, then MTHI op1=0x12345678: `done` in cycle 2, then hi=0x12345678, lo=0 from cycle 3.
- MULT 0xFFFFFFFE × 3 with a 4-cycle engine stub: `mult_sign`=1 and begin high for 4 cycles. Result hi=0xFFFFFFFF, lo=0xFFFFFFFA; one `done` pulse.
- DIVU 100/7: hi=2, lo=14. Then DIV op2=0: HI/LO unchanged, `div_begin` never rises, `done` 2 cycles after accept.
- MULTU 5×5 with `cancel` in the same cycle as `mult_end`: state→IDLE, HI/LO unchanged, no `done`, begin low next cycle.
- MTLO 0xA with `cancel` during DONE: lo stays old value. A back-to-back request during busy gets `req_ready`=0 until IDLE.
- resetn=0 mid-DIV: next cycle begin=0, HI=LO=0, `busy`=0; an engine `div_end` arriving afterwards is ignored.
